// File: rtl/irda_receiver.sv
// IrDA SIR receive datapath: decodes RZI pulses (low pulse = 0, no pulse = 1)
// into one UART-format byte: start, 8 data bits LSB-first, optional parity, stop.
// Optional feature: define IRDA_RX_PARITY_EN to add an even-parity window
// after the data bits. When it is undefined there is no parity window and
// parity_err_o is tied to 0.
module irda_receiver #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned MIN_PULSE    = 16,
   parameter int unsigned CNT_W        = 13
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       soft_rst_i,
   input  logic       ena_i,
   input  logic       start_i,
   input  logic       ir_rx_i,
   output logic [7:0] data_out_o,
   output logic       rcv_done_o,
   output logic       frame_err_o,
   output logic       parity_err_o,
   output logic       busy_o
);

   localparam int unsigned RunW = $clog2(MIN_PULSE + 1);

`ifdef IRDA_RX_PARITY_EN
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StStart = 3'd1,
      StData  = 3'd2,
      StPar   = 3'd3,
      StStop  = 3'd4,
      StDone  = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StStart = 3'd1,
      StData  = 3'd2,
      StStop  = 3'd4,
      StDone  = 3'd5
   } state_e;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] win_q, win_d;
   logic [RunW-1:0]  run_q, run_d;
   logic             seen_q, seen_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             ferr_q, ferr_d;
   logic             rx_meta_q, rx_s_q;

   // Intermediate decode signals
   logic             win_end;
   logic             in_frame;
   logic [RunW-1:0]  run_nxt;
   logic             seen_now;
   logic             bit_dec;

`ifdef IRDA_RX_PARITY_EN
   logic             par_q, par_d;
   logic             perr_q, perr_d;
`endif

   // Two-flop synchronizer on the raw IR line; idles high
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else if (soft_rst_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= ir_rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Low-run and window decode helpers
   always_comb begin
      win_end  = (win_q == CNT_W'(CLKS_PER_BIT - 1));
      in_frame = (state_q != StIdle) && (state_q != StDone);
      // Saturating run of consecutive synchronized-low samples
      if (rx_s_q) begin
         run_nxt = '0;
      end else if (run_q == RunW'(MIN_PULSE)) begin
         run_nxt = run_q;
      end else begin
         run_nxt = run_q + RunW'(1);
      end
      // Include this cycle's sample so a pulse ending on the last cycle still counts
      seen_now = seen_q | (run_nxt == RunW'(MIN_PULSE));
      bit_dec  = ~seen_now;
   end

   // Next-state logic: FSM, window/run counters, shift register and flags
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      run_d   = run_q;
      seen_d  = seen_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      ferr_d  = ferr_q;
`ifdef IRDA_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = perr_q;
`endif

      if (ena_i && in_frame) begin
         if (win_end) begin
            win_d  = '0;
            run_d  = '0;
            seen_d = 1'b0;
         end else begin
            win_d  = win_q + CNT_W'(1);
            run_d  = run_nxt;
            seen_d = seen_now;
         end
      end

      if (ena_i) begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_d = StStart;
                  win_d   = '0;
                  run_d   = '0;
                  seen_d  = 1'b0;
                  ferr_d  = 1'b0;
`ifdef IRDA_RX_PARITY_EN
                  perr_d  = 1'b0;
`endif
               end
            end
            StStart: begin
               if (win_end) begin
                  if (!seen_now) begin
                     // No start pulse: abort, keep the previous byte
                     state_d = StDone;
                     ferr_d  = 1'b1;
                  end else begin
                     state_d = StData;
                     idx_d   = 3'd0;
                  end
               end
            end
            StData: begin
               if (win_end) begin
                  shift_d[idx_q] = bit_dec;
                  idx_d          = idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
`ifdef IRDA_RX_PARITY_EN
                     state_d = StPar;
`else
                     state_d = StStop;
`endif
                  end
               end
            end
`ifdef IRDA_RX_PARITY_EN
            StPar: begin
               if (win_end) begin
                  par_d   = bit_dec;
                  state_d = StStop;
               end
            end
`endif
            StStop: begin
               if (win_end) begin
                  // A pulse in the stop window is a framing error; byte kept anyway
                  ferr_d  = seen_now;
                  data_d  = shift_q;
`ifdef IRDA_RX_PARITY_EN
                  perr_d  = par_q ^ (^shift_q);
`endif
                  state_d = StDone;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      // Controller-issued clear outranks everything else
      if (soft_rst_i) begin
         state_d = StIdle;
         win_d   = '0;
         run_d   = '0;
         seen_d  = 1'b0;
         idx_d   = 3'd0;
         shift_d = 8'h00;
         data_d  = 8'h00;
         ferr_d  = 1'b0;
`ifdef IRDA_RX_PARITY_EN
         par_d   = 1'b0;
         perr_d  = 1'b0;
`endif
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         win_q   <= '0;
         run_q   <= '0;
         seen_q  <= 1'b0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         run_q   <= run_d;
         seen_q  <= seen_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ferr_q  <= ferr_d;
      end
   end

`ifdef IRDA_RX_PARITY_EN
   // Parity capture and parity error flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         par_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         par_q  <= par_d;
         perr_q <= perr_d;
      end
   end

   assign parity_err_o = perr_q;
`else
   assign parity_err_o = 1'b0;
`endif

   assign data_out_o  = data_q;
   assign frame_err_o = ferr_q;
   assign rcv_done_o  = (state_q == StDone);
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_irda_receiver.sv
// Directed bench for irda_receiver with CLKS_PER_BIT=16, MIN_PULSE=2.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_irda_receiver;

   logic       clk_i;
   logic       rst_ni;
   logic       soft_rst_i;
   logic       ena_i;
   logic       start_i;
   logic       ir_rx_i;
   logic [7:0] data_out_o;
   logic       rcv_done_o;
   logic       frame_err_o;
   logic       parity_err_o;
   logic       busy_o;

   int checks = 0;
   int errors = 0;

   irda_receiver #(
      .CLKS_PER_BIT(16),
      .MIN_PULSE   (2),
      .CNT_W       (5)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .soft_rst_i  (soft_rst_i),
      .ena_i       (ena_i),
      .start_i     (start_i),
      .ir_rx_i     (ir_rx_i),
      .data_out_o  (data_out_o),
      .rcv_done_o  (rcv_done_o),
      .frame_err_o (frame_err_o),
      .parity_err_o(parity_err_o),
      .busy_o      (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One frame; window k spans 16 enabled edges, a 0 bit is a 3-cycle low pulse.
   // abort_win >= 0 issues a soft reset inside that window and returns.
   task automatic send_frame(input logic [7:0] b, input bit start_err, input bit stop_pulse,
                             input int glitch_win, input int gap_win, input bit bad_par,
                             input int abort_win, input logic [7:0] exp_data,
                             input bit exp_ferr, input bit exp_perr);
      logic [10:0] bits;
      int          nwin;
      int          last;
      bit          low;
      bits      = '1;
      bits[0]   = start_err;
      bits[8:1] = b;
`ifdef IRDA_RX_PARITY_EN
      nwin    = 11;
      bits[9] = (^b) ^ bad_par;
`else
      nwin    = 10;
`endif
      start_i = 1'b1;
      ena_i   = 1'b1;
      step();
      start_i = 1'b0;
      chk("busy_accept", {7'd0, busy_o}, 8'd1);
      chk("ferr_clear", {7'd0, frame_err_o}, 8'd0);
      for (int k = 0; k < nwin; k++) begin
         last = (k == gap_win) ? 21 : 16;
         for (int j = 1; j <= last; j++) begin
            low = ((!bits[k] || (k == nwin - 1 && stop_pulse)) && j >= 4 && j <= 6) ||
                  (k == glitch_win && j == 10);
            ir_rx_i = ~low;
            ena_i   = !(k == gap_win && j >= 10 && j <= 14);
            if (k == abort_win && j == 8) begin
               soft_rst_i = 1'b1;
               step();
               soft_rst_i = 1'b0;
               ir_rx_i    = 1'b1;
               ena_i      = 1'b1;
               chk("abort_busy", {7'd0, busy_o}, 8'd0);
               chk("abort_done", {7'd0, rcv_done_o}, 8'd0);
               chk("abort_data", data_out_o, exp_data);
               return;
            end
            step();
            if (j == last - 1 && (k == nwin - 1 || (start_err && k == 0)))
               chk("done_early", {7'd0, rcv_done_o}, 8'd0);
         end
         if (start_err) break;
      end
      ir_rx_i = 1'b1;
      ena_i   = 1'b1;
      chk("done_pulse", {7'd0, rcv_done_o}, 8'd1);
      chk("busy_in_done", {7'd0, busy_o}, 8'd1);
      chk("data", data_out_o, exp_data);
      chk("frame_err", {7'd0, frame_err_o}, {7'd0, exp_ferr});
      chk("parity_err", {7'd0, parity_err_o}, {7'd0, exp_perr});
      step();
      chk("done_cleared", {7'd0, rcv_done_o}, 8'd0);
      chk("busy_cleared", {7'd0, busy_o}, 8'd0);
      chk("data_hold", data_out_o, exp_data);
      chk("ferr_hold", {7'd0, frame_err_o}, {7'd0, exp_ferr});
   endtask

   initial begin
      bit any_done;
      rst_ni     = 1'b0;
      soft_rst_i = 1'b0;
      ena_i      = 1'b0;
      start_i    = 1'b0;
      ir_rx_i    = 1'b1;
      #2;
      chk("rst_data", data_out_o, 8'h00);
      chk("rst_done", {7'd0, rcv_done_o}, 8'd0);
      chk("rst_ferr", {7'd0, frame_err_o}, 8'd0);
      chk("rst_perr", {7'd0, parity_err_o}, 8'd0);
      chk("rst_busy", {7'd0, busy_o}, 8'd0);
      step();
      rst_ni = 1'b1;
      step();
      step();

      // Clean byte
      send_frame(8'hA5, 1'b0, 1'b0, -1, -1, 1'b0, -1, 8'hA5, 1'b0, 1'b0);
      step();
      // Missing start pulse: early abort, previous byte kept
      send_frame(8'h00, 1'b1, 1'b0, -1, -1, 1'b0, -1, 8'hA5, 1'b1, 1'b0);
      step();
      // Pulse in the stop window
      send_frame(8'hFF, 1'b0, 1'b1, -1, -1, 1'b0, -1, 8'hFF, 1'b1, 1'b0);
      step();
      // 1-cycle glitch is shorter than MIN_PULSE
      send_frame(8'hFF, 1'b0, 1'b0, 3, -1, 1'b0, -1, 8'hFF, 1'b0, 1'b0);
      step();
      // ena low for 5 cycles in window 4 stretches the frame
      send_frame(8'h3C, 1'b0, 1'b0, -1, 4, 1'b0, -1, 8'h3C, 1'b0, 1'b0);
      step();
      // Soft reset mid-frame clears everything, no completion follows
      send_frame(8'h55, 1'b0, 1'b0, -1, -1, 1'b0, 5, 8'h00, 1'b0, 1'b0);
      any_done = 1'b0;
      for (int i = 0; i < 180; i++) begin
         step();
         if (rcv_done_o) any_done = 1'b1;
      end
      chk("no_done_after_abort", {7'd0, any_done}, 8'd0);
      chk("idle_after_abort", {7'd0, busy_o}, 8'd0);
      send_frame(8'h81, 1'b0, 1'b0, -1, -1, 1'b0, -1, 8'h81, 1'b0, 1'b0);
      step();
`ifdef IRDA_RX_PARITY_EN
      // 0x07 has odd weight; parity bit 0 is wrong
      send_frame(8'h07, 1'b0, 1'b0, -1, -1, 1'b1, -1, 8'h07, 1'b0, 1'b1);
`else
      send_frame(8'h07, 1'b0, 1'b0, -1, -1, 1'b1, -1, 8'h07, 1'b0, 1'b0);
`endif
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
